// File: rtl/pmodacl2_sample_reader_if.sv
// Host command/response channel for pmodacl2_sample_reader.
// master = host side, slave = reader side.
interface pmodacl2_sample_reader_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [5:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/pmodacl2_sample_reader.sv
// SPI mode-0 master for the ADXL362 on a PmodACL2: host register access plus INT1-driven XYZ bursts.
// Define PMODACL2_READER_TEMP_EN to extend each burst with TEMP_L/TEMP_H and drive temperature.
module pmodacl2_sample_reader #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                           clk_sys,
    input  logic                           rst,
    pmodacl2_sample_reader_if.slave        host,
    input  logic                           auto_en,
    input  logic                           int1,
    output logic                           sample_valid,
    output logic [11:0]                    xdata,
    output logic [11:0]                    ydata,
    output logic [11:0]                    zdata,
    output logic [11:0]                    temperature,
    output logic                           SCLK,
    output logic                           MOSI,
    output logic                           nCS,
    input  logic                           MISO
);

`ifdef PMODACL2_READER_TEMP_EN
    localparam int unsigned BurstBytes = 10;
`else
    localparam int unsigned BurstBytes = 8;
`endif
    // Received bytes after instruction/address, oldest in the top byte.
    localparam int unsigned HistW     = 8 * (BurstBytes - 2);
    localparam logic [3:0]  CmdLast   = 4'd2;
    localparam logic [3:0]  BurstLast = 4'(BurstBytes - 1);
    localparam logic [7:0]  DivLast   = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StCsSetup, StShift, StCsHold, StCsGap} state_e;

    state_e           state_q, state_d;
    logic [7:0]       div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [3:0]       byte_q, byte_d;
    logic             burst_q, burst_d;
    logic             write_q, write_d;
    logic [5:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [HistW-1:0] hist_q, hist_d;
    logic             sclk_q, sclk_d;
    logic             ncs_q, ncs_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;
    logic             smp_valid_q, smp_valid_d;
    logic [11:0]      x_q, x_d, y_q, y_d, z_q, z_d;
    logic             int1_meta_q, int1_sync_q;
    logic             div_done, last_byte, burst_done;
    logic [7:0]       next_byte;
    logic             unused_hist;

    assign div_done   = (div_q == DivLast);
    assign last_byte  = burst_q ? (byte_q == BurstLast) : (byte_q == CmdLast);
    assign burst_done = (state_q == StCsHold) && div_done && burst_q;

    // Byte to send after the one currently finishing.
    always_comb begin
        next_byte = 8'h00;
        if (byte_q == 4'd0) begin
            next_byte = burst_q ? 8'h0E : {2'b00, addr_q};
        end else if (byte_q == 4'd1 && !burst_q && write_q) begin
            next_byte = wdata_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        burst_d     = burst_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        hist_d      = hist_q;
        sclk_d      = sclk_q;
        ncs_d       = ncs_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        smp_valid_d = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        case (state_q)
            StIdle: begin
                ncs_d  = 1'b1;
                sclk_d = 1'b0;
                div_d  = 8'd0;
                if (host.cmd_valid || (auto_en && int1_sync_q)) begin
                    state_d = StCsSetup;
                    ncs_d   = 1'b0;
                    bit_d   = 3'd0;
                    byte_d  = 4'd0;
                    burst_d = !host.cmd_valid;
                    tx_d    = (host.cmd_valid && host.cmd_write) ? 8'h0A : 8'h0B;
                    if (host.cmd_valid) begin
                        write_d = host.cmd_write;
                        addr_d  = host.cmd_addr;
                        wdata_d = host.cmd_wdata;
                    end
                end
            end
            StCsSetup: begin
                div_d = div_q + 8'd1;
                if (div_done) begin
                    div_d   = 8'd0;
                    state_d = StShift;
                end
            end
            StShift: begin
                div_d = div_q + 8'd1;
                if (div_done) begin
                    div_d = 8'd0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], MISO};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            hist_d = {hist_q[HistW-9:0], rx_q};
                            if (last_byte) begin
                                state_d = StCsHold;
                                tx_d    = 8'h00;
                            end else begin
                                byte_d = byte_q + 4'd1;
                                bit_d  = 3'd0;
                                tx_d   = next_byte;
                            end
                        end else begin
                            bit_d = bit_q + 3'd1;
                            tx_d  = {tx_q[6:0], 1'b0};
                        end
                    end
                end
            end
            StCsHold: begin
                div_d = div_q + 8'd1;
                if (div_done) begin
                    div_d   = 8'd0;
                    state_d = StCsGap;
                    ncs_d   = 1'b1;
                    if (burst_q) begin
                        smp_valid_d = 1'b1;
                        x_d = {hist_q[HistW-13 -: 4], hist_q[HistW-1  -: 8]};
                        y_d = {hist_q[HistW-29 -: 4], hist_q[HistW-17 -: 8]};
                        z_d = {hist_q[HistW-45 -: 4], hist_q[HistW-33 -: 8]};
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = hist_q[7:0];
                    end
                end
            end
            StCsGap: begin
                div_d = div_q + 8'd1;
                if (div_done) begin
                    div_d   = 8'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q     <= StIdle;
            div_q       <= 8'd0;
            bit_q       <= 3'd0;
            byte_q      <= 4'd0;
            burst_q     <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 6'd0;
            wdata_q     <= 8'd0;
            tx_q        <= 8'd0;
            rx_q        <= 8'd0;
            hist_q      <= '0;
            sclk_q      <= 1'b0;
            ncs_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
            smp_valid_q <= 1'b0;
            x_q         <= 12'd0;
            y_q         <= 12'd0;
            z_q         <= 12'd0;
            int1_meta_q <= 1'b0;
            int1_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            burst_q     <= burst_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            hist_q      <= hist_d;
            sclk_q      <= sclk_d;
            ncs_q       <= ncs_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            smp_valid_q <= smp_valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            int1_meta_q <= int1;
            int1_sync_q <= int1_meta_q;
        end
    end

`ifdef PMODACL2_READER_TEMP_EN
    logic [11:0] t_q;
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            t_q <= 12'd0;
        end else if (burst_done) begin
            t_q <= {hist_q[3:0], hist_q[15:8]};
        end
    end
    assign temperature = t_q;
`else
    assign temperature = 12'd0;
`endif

    // Sign-extension nibbles of the H bytes are intentionally dropped.
    assign unused_hist    = ^{hist_q, burst_done};
    assign host.cmd_ready = (state_q == StIdle) && !rst;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;
    assign sample_valid   = smp_valid_q;
    assign xdata          = x_q;
    assign ydata          = y_q;
    assign zdata          = z_q;
    assign SCLK           = sclk_q;
    assign MOSI           = tx_q[7];
    assign nCS            = ncs_q;

endmodule
